d_stage_hazard_scoreboard: RTL and testbench

Parametrised operand-hazard unit for the decode stage. It generalises the fixed X/M/W bypass and load-use stall to NUM_BYP ordered bypass stages, each with a per-stage data-ready flag. It also adds a register scoreboard for long-latency producers (mul/div) that leave the pipeline and write back out of band. It produces the forwarded operands, the decode stall, and the issue handshake.

---
 rtl/d_stage_hazard_scoreboard.sv | 143 ++++++++++++++
 tb/tb_d_stage_hazard_scoreboard.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_stage_hazard_scoreboard.sv
// Decode-stage operand hazard unit: ordered multi-stage bypass with per-stage ready,
// plus a register scoreboard and outstanding counter for out-of-band long-latency ops.
module d_stage_hazard_scoreboard #(
  parameter int N_BITS   = 32,
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int NUM_BYP  = 3,
  parameter int MAX_LNG  = 4,
  parameter int CNT_W    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_vld,
  input  logic                        flush,
  input  logic [IDX_W-1:0]            issue_rs1,
  input  logic [IDX_W-1:0]            issue_rs2,
  input  logic                        issue_rs1_vld,
  input  logic                        issue_rs2_vld,
  input  logic [IDX_W-1:0]            issue_rd,
  input  logic                        issue_wr_en,
  input  logic                        issue_lng,
  input  logic [N_BITS-1:0]           rf_rs1_data,
  input  logic [N_BITS-1:0]           rf_rs2_data,
  input  logic [NUM_BYP*IDX_W-1:0]    byp_rd,
  input  logic [NUM_BYP-1:0]          byp_wr_en,
  input  logic [NUM_BYP-1:0]          byp_rdy,
  input  logic [NUM_BYP*N_BITS-1:0]   byp_data,
  input  logic                        lng_wb_vld,
  input  logic [IDX_W-1:0]            lng_wb_rd,
  input  logic [N_BITS-1:0]           lng_wb_data,
  output logic [N_BITS-1:0]           op1,
  output logic [N_BITS-1:0]           op2,
  output logic                        stall,
  output logic                        issue_fire,
  output logic [CNT_W-1:0]            lng_outstanding,
  output logic [NUM_REGS-1:0]         pend_vec
);

  logic [NUM_REGS-1:0] pend_reg, pend_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  logic [2*IDX_W-1:0]  src_idx_flat;
  logic [1:0]          src_vld_flat;
  logic [2*N_BITS-1:0] src_rf_flat;
  logic [2*N_BITS-1:0] src_op_flat;
  logic [1:0]          src_haz_flat;

  assign src_idx_flat = {issue_rs2, issue_rs1};
  assign src_vld_flat = {issue_rs2_vld, issue_rs1_vld};
  assign src_rf_flat  = {rf_rs2_data, rf_rs1_data};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [IDX_W-1:0]  idx;
      logic              byp_hit;
      logic              byp_ok;
      logic [N_BITS-1:0] byp_val;
      logic [N_BITS-1:0] res;
      logic              haz;

      assign idx = src_idx_flat[gi*IDX_W +: IDX_W];

      // Walk oldest to youngest so the youngest matching stage wins.
      always_comb begin
        byp_hit = 1'b0;
        byp_ok  = 1'b0;
        byp_val = '0;
        for (int i = NUM_BYP - 1; i >= 0; i--) begin
          if (byp_wr_en[i] && (byp_rd[i*IDX_W +: IDX_W] == idx)) begin
            byp_hit = 1'b1;
            byp_ok  = byp_rdy[i];
            byp_val = byp_data[i*N_BITS +: N_BITS];
          end
        end
      end

      always_comb begin
        res = src_rf_flat[gi*N_BITS +: N_BITS];
        haz = 1'b0;
        if (!src_vld_flat[gi] || (idx == '0)) begin
          res = src_rf_flat[gi*N_BITS +: N_BITS];
        end else if (lng_wb_vld && (lng_wb_rd == idx)) begin
          res = lng_wb_data;
        end else if (pend_reg[idx]) begin
          haz = 1'b1;
        end else if (byp_hit) begin
          if (byp_ok) res = byp_val;
          else        haz = 1'b1;
        end
      end

      assign src_op_flat[gi*N_BITS +: N_BITS] = res;
      assign src_haz_flat[gi]                 = haz;
    end
  endgenerate

  assign op1 = src_op_flat[0 +: N_BITS];
  assign op2 = src_op_flat[N_BITS +: N_BITS];

  logic waw, full, inc, dec;

  assign waw = issue_wr_en && (issue_rd != '0) && pend_reg[issue_rd]
               && !(lng_wb_vld && (lng_wb_rd == issue_rd));
  assign full = issue_lng && (cnt_reg == CNT_W'(MAX_LNG)) && !lng_wb_vld;

  assign stall      = issue_vld && !flush && ((|src_haz_flat) || waw || full);
  assign issue_fire = issue_vld && !flush && !stall;

  assign inc = issue_fire && issue_lng;
  assign dec = lng_wb_vld && (cnt_reg != '0);

  always_comb begin
    pend_next = pend_reg;
    if (lng_wb_vld && (lng_wb_rd != '0)) pend_next[lng_wb_rd] = 1'b0;
    // A new long issue to the same register must survive the old completion.
    if (inc && issue_wr_en && (issue_rd != '0)) pend_next[issue_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (inc && !dec && (cnt_reg != CNT_W'(MAX_LNG))) cnt_next = cnt_reg + CNT_W'(1);
    else if (dec && !inc)                            cnt_next = cnt_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign pend_vec        = pend_reg;
  assign lng_outstanding = cnt_reg;

  a_wb_underflow: assert property (@(posedge clk) disable iff (rst)
    !(lng_wb_vld && (cnt_reg == '0)));

endmodule

// File: tb/tb_d_stage_hazard_scoreboard.sv
// Directed plus randomized check of the decode hazard unit against a queue-based model
// of the long-latency unit and a rule-level operand resolver.
module tb_d_stage_hazard_scoreboard;
  localparam int N_BITS = 32, NUM_REGS = 32, IDX_W = 5, NUM_BYP = 3, MAX_LNG = 4, CNT_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, issue_vld, flush, issue_rs1_vld, issue_rs2_vld, issue_wr_en, issue_lng;
  logic [IDX_W-1:0] issue_rs1, issue_rs2, issue_rd, lng_wb_rd;
  logic [N_BITS-1:0] rf_rs1_data, rf_rs2_data, lng_wb_data, op1, op2;
  logic [NUM_BYP*IDX_W-1:0] byp_rd;
  logic [NUM_BYP-1:0] byp_wr_en, byp_rdy;
  logic [NUM_BYP*N_BITS-1:0] byp_data;
  logic lng_wb_vld, stall, issue_fire;
  logic [CNT_W-1:0] lng_outstanding;
  logic [NUM_REGS-1:0] pend_vec;

  d_stage_hazard_scoreboard #(.N_BITS(N_BITS), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W),
    .NUM_BYP(NUM_BYP), .MAX_LNG(MAX_LNG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .issue_vld(issue_vld), .flush(flush),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_vld(issue_rs1_vld), .issue_rs2_vld(issue_rs2_vld),
    .issue_rd(issue_rd), .issue_wr_en(issue_wr_en), .issue_lng(issue_lng),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .byp_rd(byp_rd), .byp_wr_en(byp_wr_en), .byp_rdy(byp_rdy), .byp_data(byp_data),
    .lng_wb_vld(lng_wb_vld), .lng_wb_rd(lng_wb_rd), .lng_wb_data(lng_wb_data),
    .op1(op1), .op2(op2), .stall(stall), .issue_fire(issue_fire),
    .lng_outstanding(lng_outstanding), .pend_vec(pend_vec));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: pending flags per register and the long unit's in-flight queue.
  bit pend_m [NUM_REGS];
  logic [IDX_W-1:0] lq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_vld = 0; flush = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs1_vld = 0; issue_rs2_vld = 0;
    issue_rd = 0; issue_wr_en = 0; issue_lng = 0; rf_rs1_data = 0; rf_rs2_data = 0;
    byp_rd = 0; byp_wr_en = 0; byp_rdy = 0; byp_data = 0;
    lng_wb_vld = 0; lng_wb_rd = 0; lng_wb_data = 0;
  endtask

  task automatic set_byp(input int s, input logic [IDX_W-1:0] rd, input logic rdy, input logic [N_BITS-1:0] d);
    byp_rd[s*IDX_W +: IDX_W] = rd;
    byp_wr_en[s] = 1'b1;
    byp_rdy[s] = rdy;
    byp_data[s*N_BITS +: N_BITS] = d;
  endtask

  task automatic issue(input logic [IDX_W-1:0] rs1, input logic v1, input logic [IDX_W-1:0] rs2,
                       input logic v2, input logic [IDX_W-1:0] rd, input logic lng);
    issue_vld = 1; issue_rs1 = rs1; issue_rs1_vld = v1; issue_rs2 = rs2; issue_rs2_vld = v2;
    issue_rd = rd; issue_wr_en = 1; issue_lng = lng;
    rf_rs1_data = 32'h1111_0001; rf_rs2_data = 32'h2222_0002;
  endtask

  // Rule-level resolution of one source: first matching rule decides, youngest stage first.
  function automatic void resolve(input logic [IDX_W-1:0] idx, input logic v, input logic [N_BITS-1:0] rf,
                                  output logic [N_BITS-1:0] val, output bit haz);
    haz = 0;
    val = rf;
    if (!v || idx == 0) return;
    if (lng_wb_vld && lng_wb_rd == idx) begin val = lng_wb_data; return; end
    if (pend_m[idx]) begin haz = 1; return; end
    for (int i = 0; i < NUM_BYP; i++) begin
      if (byp_wr_en[i] && byp_rd[i*IDX_W +: IDX_W] == idx) begin
        if (byp_rdy[i]) val = byp_data[i*N_BITS +: N_BITS];
        else haz = 1;
        return;
      end
    end
  endfunction

  task automatic rand_cycle(input int n);
    logic [N_BITS-1:0] e1, e2;
    logic [NUM_REGS-1:0] pexp;
    bit h1, h2, waw, full, e_stall, e_fire;
    idle();
    issue_vld = ($urandom_range(0, 3) != 0);
    flush = ($urandom_range(0, 7) == 0);
    issue_rs1 = IDX_W'($urandom_range(0, 7)); issue_rs2 = IDX_W'($urandom_range(0, 7));
    issue_rs1_vld = $urandom_range(0, 1) != 0; issue_rs2_vld = $urandom_range(0, 1) != 0;
    issue_rd = IDX_W'($urandom_range(0, 7)); issue_wr_en = $urandom_range(0, 3) != 0;
    issue_lng = $urandom_range(0, 2) == 0;
    rf_rs1_data = $urandom; rf_rs2_data = $urandom;
    for (int s = 0; s < NUM_BYP; s++) begin
      byp_rd[s*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 7));
      byp_wr_en[s] = $urandom_range(0, 1) != 0;
      byp_rdy[s] = $urandom_range(0, 3) != 0;
      byp_data[s*N_BITS +: N_BITS] = $urandom;
    end
    if (lq.size() > 0 && $urandom_range(0, 1) != 0) begin
      lng_wb_vld = 1; lng_wb_rd = lq[0]; lng_wb_data = $urandom;
    end
    #1;
    resolve(issue_rs1, issue_rs1_vld, rf_rs1_data, e1, h1);
    resolve(issue_rs2, issue_rs2_vld, rf_rs2_data, e2, h2);
    waw = issue_wr_en && issue_rd != 0 && pend_m[issue_rd] && !(lng_wb_vld && lng_wb_rd == issue_rd);
    full = issue_lng && lq.size() == MAX_LNG && !lng_wb_vld;
    e_stall = issue_vld && !flush && (h1 || h2 || waw || full);
    e_fire = issue_vld && !flush && !e_stall;
    $display("[TB] rnd %0d vld=%0d fl=%0d rs1=%0d rs2=%0d rd=%0d lng=%0d wb=%0d q=%0d stall=%0d", n,
             issue_vld, flush, issue_rs1, issue_rs2, issue_rd, issue_lng, lng_wb_vld, lq.size(), e_stall);
    if (!h1) chk("rnd_op1", 64'(op1), 64'(e1));
    if (!h2) chk("rnd_op2", 64'(op2), 64'(e2));
    chk("rnd_stall", 64'(stall), 64'(e_stall));
    chk("rnd_fire", 64'(issue_fire), 64'(e_fire));
    tick();
    if (lng_wb_vld) begin
      void'(lq.pop_front());
      if (lng_wb_rd != 0) pend_m[lng_wb_rd] = 0;
    end
    if (e_fire && issue_lng) begin
      lq.push_back(issue_wr_en ? issue_rd : IDX_W'(0));
      if (issue_wr_en && issue_rd != 0) pend_m[issue_rd] = 1;
    end
    pexp = '0;
    for (int r = 0; r < NUM_REGS; r++) pexp[r] = pend_m[r];
    chk("rnd_pend", 64'(pend_vec), 64'(pexp));
    chk("rnd_cnt", 64'(lng_outstanding), 64'(lq.size()));
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    $display("[TB] reset released");
    chk("rst_pend", 64'(pend_vec), 64'h0);
    chk("rst_cnt", 64'(lng_outstanding), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);

    // add x3,x1,x2 with no bypass activity
    issue(1, 1, 2, 1, 3, 0); #1;
    $display("[TB] add x3,x1,x2");
    chk("add_op1", 64'(op1), 64'h1111_0001);
    chk("add_op2", 64'(op2), 64'h2222_0002);
    chk("add_stall", 64'(stall), 64'h0);
    chk("add_fire", 64'(issue_fire), 64'h1);
    tick();
    chk("add_pend", 64'(pend_vec), 64'h0);

    // youngest stage wins over W
    idle(); issue(5, 1, 2, 1, 3, 0);
    set_byp(0, 5, 1, 32'hAAAA); set_byp(2, 5, 1, 32'h1111); #1;
    $display("[TB] bypass priority rs1=x5");
    chk("byp_op1", 64'(op1), 64'hAAAA);
    chk("byp_stall", 64'(stall), 64'h0);
    tick();

    // load-use stall, then bypass from M
    idle(); issue(1, 1, 7, 1, 3, 0); set_byp(0, 7, 0, 32'hDEAD); #1;
    $display("[TB] load-use rs2=x7");
    chk("lu_stall", 64'(stall), 64'h1);
    chk("lu_fire", 64'(issue_fire), 64'h0);
    tick();
    idle(); issue(1, 1, 7, 1, 3, 0); set_byp(1, 7, 1, 32'h42); #1;
    chk("lu_op2", 64'(op2), 64'h42);
    chk("lu_fire2", 64'(issue_fire), 64'h1);
    tick();

    // div x9, dependent read, writeback forwarding
    idle(); issue(1, 1, 2, 1, 9, 1); #1;
    $display("[TB] div x9");
    chk("div_fire", 64'(issue_fire), 64'h1);
    tick();
    chk("div_pend", 64'(pend_vec), 64'h200);
    chk("div_cnt", 64'(lng_outstanding), 64'h1);
    idle(); issue(9, 1, 2, 0, 10, 0); #1;
    chk("dep_stall", 64'(stall), 64'h1);
    tick();
    lng_wb_vld = 1; lng_wb_rd = 9; lng_wb_data = 32'h77; #1;
    $display("[TB] wb x9 forwarded");
    chk("wb_op1", 64'(op1), 64'h77);
    chk("wb_stall", 64'(stall), 64'h0);
    chk("wb_fire", 64'(issue_fire), 64'h1);
    tick();
    idle();
    chk("wb_pend", 64'(pend_vec), 64'h0);
    chk("wb_cnt", 64'(lng_outstanding), 64'h0);

    // fill to MAX_LNG, 5th waits, fires alongside a writeback
    for (int k = 0; k < MAX_LNG; k++) begin
      idle(); issue(0, 0, 0, 0, IDX_W'(11 + k), 1); #1;
      $display("[TB] long issue x%0d", 11 + k);
      chk("fill_fire", 64'(issue_fire), 64'h1);
      tick();
    end
    chk("fill_cnt", 64'(lng_outstanding), 64'(MAX_LNG));
    chk("fill_pend", 64'(pend_vec), 64'h7800);
    idle(); issue(0, 0, 0, 0, 15, 1); #1;
    chk("full_stall", 64'(stall), 64'h1);
    lng_wb_vld = 1; lng_wb_rd = 11; lng_wb_data = 32'h5; #1;
    $display("[TB] 5th long op with wb x11");
    chk("full_fire", 64'(issue_fire), 64'h1);
    tick();
    chk("full_cnt", 64'(lng_outstanding), 64'(MAX_LNG));
    chk("full_pend", 64'(pend_vec), 64'hF000);
    for (int k = 12; k <= 15; k++) begin
      idle(); lng_wb_vld = 1; lng_wb_rd = IDX_W'(k); tick();
    end
    idle();
    chk("drain_cnt", 64'(lng_outstanding), 64'h0);
    chk("drain_pend", 64'(pend_vec), 64'h0);

    // set beats clear on the same register
    issue(0, 0, 0, 0, 9, 1); tick();
    lng_wb_vld = 1; lng_wb_rd = 9; #1;
    $display("[TB] wb x9 with new long issue x9");
    chk("sbc_fire", 64'(issue_fire), 64'h1);
    tick();
    idle();
    chk("sbc_pend", 64'(pend_vec), 64'h200);
    chk("sbc_cnt", 64'(lng_outstanding), 64'h1);

    // flush suppresses stall and fire
    issue(9, 1, 0, 0, 4, 0); flush = 1; #1;
    $display("[TB] flush with hazard");
    chk("fl_stall", 64'(stall), 64'h0);
    chk("fl_fire", 64'(issue_fire), 64'h0);

    // reset with pending state
    idle(); rst = 1; tick();
    $display("[TB] reset with pend set");
    chk("rst2_pend", 64'(pend_vec), 64'h0);
    chk("rst2_cnt", 64'(lng_outstanding), 64'h0);
    rst = 0;

    for (int r = 0; r < NUM_REGS; r++) pend_m[r] = 0;
    lq.delete();
    for (int n = 0; n < 400; n++) rand_cycle(n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
